psg_bus_master: RTL and testbench
=================================

// Module: psg_bus_master
// PURPOSE
// - CPU-side bus master for the PSG register interface: converts queued register
//   read/write commands into addr/din/cs_n/wr_n bus cycles and returns read data.
// - Sits between a sound CPU or script engine and the PSG core; lets firmware-less
//   logic program tone, noise, mixer and envelope registers without bus timing knowledge.
// PARAMETERS
// - DEPTH     4  command FIFO entries; power of two, >=2
// - WR_PULSE  2  clk cycles cs_n/wr_n held low per write; >=1
// - RD_LAT    2  clk cycles cs_n held low per read before sampling psg_dout; >=2
// - GAP       1  idle clk cycles (cs_n=wr_n=1) after every bus cycle; >=1
// PORTS
// - clk         in   1  system clock, rising edge
// - rst         in   1  synchronous reset, active high
// - cmd_valid   in   1  command offered
// - cmd_ready   out  1  FIFO can accept (level < DEPTH)
// - cmd_rd      in   1  1=read, 0=write
// - cmd_addr    in   4  PSG register index
// - cmd_data    in   8  write data (ignored for reads)
// - rd_valid    out  1  one-cycle pulse: rd_data/rd_addr valid
// - rd_data     out  8  captured read data
// - rd_addr     out  4  register index of the returned read
// - busy        out  1  FIFO non-empty or bus cycle in progress
// - fifo_level  out  $clog2(DEPTH)+1  entries held
// - psg_addr    out  4  to PSG addr
// - psg_din     out  8  to PSG din
// - psg_cs_n    out  1  to PSG cs_n
// - psg_wr_n    out  1  to PSG wr_n
// - psg_dout    in   8  from PSG dout (registered in PSG, 1 clk after addr)
// BEHAVIOUR
// - Reset: psg_cs_n=1, psg_wr_n=1, psg_addr=0, psg_din=0, rd_valid=0, rd_data=0,
//   rd_addr=0, busy=0, fifo_level=0, FIFO flushed, FSM=IDLE. cmd_ready=1 after reset.
// - Push on cmd_valid&cmd_ready. cmd_ready combinational from level; push while full
//   never occurs. Same-cycle push+pop: level unchanged. FIFO is first-word-fall-through.
// - FSM: IDLE -> SETUP -> (WRITE | READ) -> GAP -> IDLE. All bus outputs registered.
//   IDLE : cs_n=wr_n=1; if FIFO non-empty, pop, latch cmd, drive psg_addr/psg_din -> SETUP.
//   SETUP: 1 cycle, addr/din stable, cs_n=wr_n=1 -> WRITE if write else READ.
//   WRITE: cs_n=0, wr_n=0 for exactly WR_PULSE cycles -> GAP.
//   READ : cs_n=0, wr_n=1 for RD_LAT cycles; psg_dout sampled at last cycle's edge into
//          rd_data, rd_addr<=psg_addr, rd_valid=1 for next cycle only -> GAP.
//   GAP  : cs_n=wr_n=1 for GAP cycles -> IDLE.
// - psg_addr/psg_din stay constant from SETUP through end of GAP (no glitches while cs_n=0).
// - Latency: write pushed into empty idle block at edge t: psg_wr_n first low cycle t+3.
//   Back-to-back cycle period = 2 + WR_PULSE(or RD_LAT) + GAP clk cycles.
// - Every write yields a distinct wr_n falling edge, so consecutive writes to register
//   0xD each retrigger the envelope; GAP>=1 guarantees this.
// - Commands issue strictly in FIFO order; reads and writes never reorder.
// - busy=1 from first push until GAP of last command completes.
// - rst asserted mid-cycle: next edge forces cs_n=wr_n=1, drops any in-flight command and
//   FIFO contents; no rd_valid for an aborted read.
// - Addresses 0xE/0xF read port inputs on the PSG; block treats them like any register.
// STRUCTURE
// - Package psg_bus_pkg: FSM state enum (IDLE,SETUP,WRITE,READ,GAP), command layout
//   constants (CMD_RD bit 12, CMD_ADDR [11:8], CMD_DATA [7:0], CMD_W=13).
// - Sub-module psg_cmd_fifo (DEPTH x CMD_W, FWFT, sync reset, level output).
// - Top: FSM + one shared down-counter loaded with WR_PULSE/RD_LAT/GAP per state.
// TESTING
// - Reset then write (addr 7, data 0x38), defaults -> wr_n low cycles t+3..t+4,
//   psg_addr=7, psg_din=0x38 stable across them; busy falls after 1 GAP cycle.
// - Two writes to 0xD back-to-back -> two separate wr_n low pulses, >=1 high cycle between;
//   PSG model counts 2 envelope restarts.
// - Read addr 1 with PSG reg1=0xA5 -> rd_valid single pulse, rd_data=0x05 (masked), rd_addr=1.
// - Push 5 commands with DEPTH=4 while stalled in WRITE -> cmd_ready=0 at level 4;
//   5th accepted only after pop; bus order matches push order.
// - Assert rst during READ's first cycle -> cs_n=1 next cycle, fifo_level=0, no rd_valid.
// - Random mixed read/write stream vs PSG model -> all reads return last written value
//   (masked), zero overlaps of cs_n low with addr change.

Source files
------------

// File: rtl/psg_bus_pkg.sv
// -----------------------------------------------------------------------------
// psg_bus_pkg
// Shared definitions for the PSG bus master: bus-cycle FSM states, the layout
// of a queued command word, and a small constant helper for sizing counters.
// No ports; imported by psg_cmd_fifo and psg_bus_master.
// -----------------------------------------------------------------------------
package psg_bus_pkg;

    // Bus-cycle sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // Command word layout: {rd, addr[3:0], data[7:0]}.
    localparam int CMD_W       = 13;
    localparam int CMD_RD      = 12;
    localparam int CMD_ADDR_HI = 11;
    localparam int CMD_ADDR_LO = 8;
    localparam int CMD_DATA_HI = 7;
    localparam int CMD_DATA_LO = 0;

    function automatic logic [CMD_W-1:0] pack_cmd(
        input logic       rd,
        input logic [3:0] addr,
        input logic [7:0] data
    );
        return {rd, addr, data};
    endfunction

    // Largest of three timing parameters; sizes the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/psg_cmd_fifo.sv
// -----------------------------------------------------------------------------
// psg_cmd_fifo
// First-word-fall-through command FIFO: the head entry is visible on o_data
// whenever o_empty is low, so the consumer pops and uses it in the same cycle.
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset (flushes the FIFO)
//   i_push, i_data     write one entry (ignored while full)
//   i_pop              discard the head entry (ignored while empty)
//   o_data             head entry
//   o_empty, o_full    occupancy flags
//   o_level            number of entries held, 0..DEPTH
// -----------------------------------------------------------------------------
module psg_cmd_fifo
    import psg_bus_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = CMD_W
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // NOTE: storage has no reset; a flush only clears pointers and level, and
    // keeping the array out of the reset path lets it map onto plain RAM/regs.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/psg_bus_master.sv
// -----------------------------------------------------------------------------
// psg_bus_master
// Turns queued PSG register read/write commands into addr/din/cs_n/wr_n bus
// cycles and returns read data, so upstream logic needs no bus timing.
// Each command runs IDLE(pop) -> SETUP -> WRITE|READ -> GAP -> IDLE, with all
// bus outputs registered and addr/din held from SETUP to the end of GAP.
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready        command handshake (ready = FIFO not full)
//   i_cmd_rd/i_cmd_addr/i_cmd_data command: 1=read, register index, write data
//   o_rd_valid/o_rd_data/o_rd_addr one-cycle read return
//   o_busy                         FIFO non-empty or bus cycle in progress
//   o_fifo_level                   entries held in the command FIFO
//   o_psg_addr/o_psg_din           PSG address and write data
//   o_psg_cs_n/o_psg_wr_n          PSG strobes, active low
//   i_psg_dout                     PSG read data (registered in the PSG)
// -----------------------------------------------------------------------------
module psg_bus_master
    import psg_bus_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int WR_PULSE = 2,
    parameter int RD_LAT   = 2,
    parameter int GAP      = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic                       i_cmd_rd,
    input  logic [3:0]                 i_cmd_addr,
    input  logic [7:0]                 i_cmd_data,
    output logic                       o_rd_valid,
    output logic [7:0]                 o_rd_data,
    output logic [3:0]                 o_rd_addr,
    output logic                       o_busy,
    output logic [$clog2(DEPTH):0]     o_fifo_level,
    output logic [3:0]                 o_psg_addr,
    output logic [7:0]                 o_psg_din,
    output logic                       o_psg_cs_n,
    output logic                       o_psg_wr_n,
    input  logic [7:0]                 i_psg_dout
);

    // The phase counter holds (cycles remaining - 1), so it never needs to
    // represent the largest timing value itself.
    localparam int CNT_MAX = max3(WR_PULSE, RD_LAT, GAP);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_is_rd;
    logic [3:0]           r_psg_addr;
    logic [7:0]           r_psg_din;
    logic                 r_psg_cs_n;
    logic                 r_psg_wr_n;
    logic                 r_rd_valid;
    logic [7:0]           r_rd_data;
    logic [3:0]           r_rd_addr;

    logic                 w_fifo_empty;
    logic                 w_fifo_full;
    logic                 w_push;
    logic                 w_pop;
    logic [CMD_W-1:0]     w_head;
    logic [$clog2(DEPTH):0] w_level;

    assign w_push = i_cmd_valid && !w_fifo_full;
    // FWFT head is consumed in the same IDLE cycle that latches it.
    assign w_pop  = (r_state == ST_IDLE) && !w_fifo_empty;

    psg_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (pack_cmd(i_cmd_rd, i_cmd_addr, i_cmd_data)),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_level (w_level)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_is_rd    <= 1'b0;
            r_psg_addr <= '0;
            r_psg_din  <= '0;
            r_psg_cs_n <= 1'b1;
            r_psg_wr_n <= 1'b1;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_addr  <= '0;
        end else begin
            // Read return is a single-cycle pulse unless READ re-arms it.
            r_rd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_is_rd    <= w_head[CMD_RD];
                        r_psg_addr <= w_head[CMD_ADDR_HI:CMD_ADDR_LO];
                        r_psg_din  <= w_head[CMD_DATA_HI:CMD_DATA_LO];
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_psg_cs_n <= 1'b0;
                    if (r_is_rd) begin
                        r_cnt   <= CNT_W'(RD_LAT - 1);
                        r_state <= ST_READ;
                    end else begin
                        r_psg_wr_n <= 1'b0;
                        r_cnt      <= CNT_W'(WR_PULSE - 1);
                        r_state    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (r_cnt == '0) begin
                        r_psg_cs_n <= 1'b1;
                        r_psg_wr_n <= 1'b1;
                        r_cnt      <= CNT_W'(GAP - 1);
                        r_state    <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_READ: begin
                    if (r_cnt == '0) begin
                        // Edge ending the last cs_n-low cycle: PSG dout has
                        // had RD_LAT cycles to settle on the held address.
                        r_psg_cs_n <= 1'b1;
                        r_rd_data  <= i_psg_dout;
                        r_rd_addr  <= r_psg_addr;
                        r_rd_valid <= 1'b1;
                        r_cnt      <= CNT_W'(GAP - 1);
                        r_state    <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    // Guaranteed high time between strobes, so back-to-back
                    // writes to the envelope shape register each retrigger.
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_psg_cs_n <= 1'b1;
                    r_psg_wr_n <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready  = !w_fifo_full;
    assign o_fifo_level = w_level;
    assign o_busy       = !w_fifo_empty || (r_state != ST_IDLE);
    assign o_psg_addr   = r_psg_addr;
    assign o_psg_din    = r_psg_din;
    assign o_psg_cs_n   = r_psg_cs_n;
    assign o_psg_wr_n   = r_psg_wr_n;
    assign o_rd_valid   = r_rd_valid;
    assign o_rd_data    = r_rd_data;
    assign o_rd_addr    = r_rd_addr;

endmodule

// File: tb/tb_psg_bus_master.sv
// -----------------------------------------------------------------------------
// tb_psg_bus_master
// Self-checking bench: a PSG register model on the bus side, a command-order
// scoreboard, and a shadow register file that predicts every read result.
// -----------------------------------------------------------------------------
module tb_psg_bus_master;

    localparam int DEPTH    = 4;
    localparam int WR_PULSE = 2;
    localparam int RD_LAT   = 2;
    localparam int GAP      = 1;
    localparam int LVL_W    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_rd;
    logic [3:0]       cmd_addr;
    logic [7:0]       cmd_data;
    logic             rd_valid;
    logic [7:0]       rd_data;
    logic [3:0]       rd_addr;
    logic             busy;
    logic [LVL_W-1:0] fifo_level;
    logic [3:0]       psg_addr;
    logic [7:0]       psg_din;
    logic             psg_cs_n;
    logic             psg_wr_n;
    logic [7:0]       psg_dout;

    always #5 clk = ~clk;

    psg_bus_master #(
        .DEPTH    (DEPTH),
        .WR_PULSE (WR_PULSE),
        .RD_LAT   (RD_LAT),
        .GAP      (GAP)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_rd     (cmd_rd),
        .i_cmd_addr   (cmd_addr),
        .i_cmd_data   (cmd_data),
        .o_rd_valid   (rd_valid),
        .o_rd_data    (rd_data),
        .o_rd_addr    (rd_addr),
        .o_busy       (busy),
        .o_fifo_level (fifo_level),
        .o_psg_addr   (psg_addr),
        .o_psg_din    (psg_din),
        .o_psg_cs_n   (psg_cs_n),
        .o_psg_wr_n   (psg_wr_n),
        .i_psg_dout   (psg_dout)
    );

    typedef struct {
        logic       rd;
        logic [3:0] addr;
        logic [7:0] data;
    } cmd_t;

    cmd_t       exp_bus_q [$];
    cmd_t       exp_rd_q  [$];
    logic [7:0] shadow   [16];
    logic [7:0] psg_regs [16];

    int checks       = 0;
    int errors       = 0;
    int env_restarts = 0;
    int proto_errs   = 0;
    int rd_pulses    = 0;
    int rd_double    = 0;
    logic [7:0] last_rd_data;
    logic [3:0] last_rd_addr;

    // AY-3-8910 style register widths: unused upper bits read back as zero.
    function automatic logic [7:0] reg_mask(input logic [3:0] a);
        case (a)
            4'd1, 4'd3, 4'd5, 4'd13:  return 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10:  return 8'h1F;
            default:                  return 8'hFF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- PSG model and bus protocol monitor (posedge) ----------
    logic       m_cs, m_wr, m_strobe;
    logic [3:0] m_a;
    logic [7:0] m_d;
    logic       prev_cs = 1'b1, prev_strobe = 1'b0;
    logic [3:0] prev_a = '0;
    logic [7:0] prev_d = '0;
    logic       aborted = 1'b1, cur_wr = 1'b0;
    int         low_run = 0, high_run = 100;
    cmd_t       m_c;

    always @(posedge clk) begin
        m_cs = psg_cs_n;
        m_wr = psg_wr_n;
        m_a  = psg_addr;
        m_d  = psg_din;
        m_strobe = !m_cs && !m_wr;
        // PSG: dout registered one clock after addr; write on strobe low.
        psg_dout <= psg_regs[m_a];
        if (m_strobe) begin
            psg_regs[m_a] = m_d & reg_mask(m_a);
            if (!prev_strobe && m_a == 4'hD) env_restarts++;
        end
        if (rst) begin
            aborted = 1'b1;
        end else begin
            if (!m_cs && !prev_cs && (m_a != prev_a || m_d != prev_d)) proto_errs++;
            if (!m_wr && m_cs) proto_errs++;
            if (!m_cs && prev_cs) begin
                low_run = 1;
                aborted = 1'b0;
                cur_wr  = !m_wr;
                check("bus_gap_min", 32'(high_run >= GAP + 2), 1);
                if (exp_bus_q.size() == 0) begin
                    check("bus_unexpected_cycle", 1, 0);
                end else begin
                    m_c = exp_bus_q.pop_front();
                    check("bus_kind_rd", 32'(m_wr), 32'(m_c.rd));
                    check("bus_addr", 32'(m_a), 32'(m_c.addr));
                    if (!m_c.rd) check("bus_din", 32'(m_d), 32'(m_c.data));
                end
            end else if (!m_cs) begin
                low_run++;
            end
            if (m_cs && !prev_cs) begin
                if (!aborted) check("bus_pulse_len", 32'(low_run), 32'(cur_wr ? WR_PULSE : RD_LAT));
                high_run = 1;
            end else if (m_cs) begin
                high_run++;
            end
        end
        prev_cs     = m_cs;
        prev_a      = m_a;
        prev_d      = m_d;
        prev_strobe = m_strobe;
    end

    // ---------------- read-return scoreboard (negedge) ----------------------
    logic prev_rdv = 1'b0;
    cmd_t r_c;

    always @(negedge clk) begin
        if (rd_valid) begin
            rd_pulses++;
            if (prev_rdv) rd_double++;
            last_rd_data = rd_data;
            last_rd_addr = rd_addr;
            if (exp_rd_q.size() == 0) begin
                check("rd_unexpected", 1, 0);
            end else begin
                r_c = exp_rd_q.pop_front();
                check("rd_addr", 32'(rd_addr), 32'(r_c.addr));
                check("rd_data", 32'(rd_data), 32'(r_c.data));
            end
        end
        prev_rdv = rd_valid;
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic push(input logic rd, input logic [3:0] a, input logic [7:0] d,
                        output int waited);
        cmd_t c;
        waited = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_rd    = rd;
        cmd_addr  = a;
        cmd_data  = d;
        while (!cmd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            check("push_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        c = '{rd, a, d};
        exp_bus_q.push_back(c);
        if (rd) begin
            c.data = shadow[a];
            exp_rd_q.push_back(c);
        end else begin
            shadow[a] = d & reg_mask(a);
        end
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- directed and random sequence --------------------------
    initial begin
        int w, env0, rdp0, n;
        logic rr;
        logic [3:0] ra;
        logic [7:0] rdat;

        for (int i = 0; i < 16; i++) begin
            psg_regs[i] = 8'h00;
            shadow[i]   = 8'h00;
        end
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_rd    = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state.
        check("rst_cs_n",   32'(psg_cs_n), 1);
        check("rst_wr_n",   32'(psg_wr_n), 1);
        check("rst_addr",   32'(psg_addr), 0);
        check("rst_din",    32'(psg_din), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data",  32'(rd_data), 0);
        check("rst_rd_addr",  32'(rd_addr), 0);
        check("rst_busy",   32'(busy), 0);
        check("rst_level",  32'(fifo_level), 0);
        check("rst_ready",  32'(cmd_ready), 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single write: strobe seen by the PSG at edges t+3 and t+4.
        push(1'b0, 4'd7, 8'h38, w);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("wr1_wr_n_k%0d", k), 32'(psg_wr_n), 32'((k == 3 || k == 4) ? 0 : 1));
            check($sformatf("wr1_cs_n_k%0d", k), 32'(psg_cs_n), 32'((k == 3 || k == 4) ? 0 : 1));
            if (k == 3 || k == 4) begin
                check($sformatf("wr1_addr_k%0d", k), 32'(psg_addr), 7);
                check($sformatf("wr1_din_k%0d", k), 32'(psg_din), 32'h38);
            end
            if (k == 1) check("wr1_level", 32'(fifo_level), 1);
            if (k == 5) check("wr1_busy_gap", 32'(busy), 1);
            if (k == 6) check("wr1_busy_done", 32'(busy), 0);
        end
        check("wr1_psg_reg7", 32'(psg_regs[7]), 32'h38);

        // Back-to-back envelope shape writes each retrigger.
        env0 = env_restarts;
        push(1'b0, 4'hD, 8'h0A, w);
        push(1'b0, 4'hD, 8'h0B, w);
        wait_idle("env_idle");
        check("env_restarts", 32'(env_restarts - env0), 2);

        // Masked read-back of register 1.
        rdp0 = rd_pulses;
        push(1'b0, 4'd1, 8'hA5, w);
        push(1'b1, 4'd1, 8'h00, w);
        wait_idle("rd1_idle");
        check("rd1_pulses", 32'(rd_pulses - rdp0), 1);
        check("rd1_data", 32'(last_rd_data), 32'h05);
        check("rd1_addr", 32'(last_rd_addr), 1);

        // Fill the FIFO while the bus is stalled in a write.
        for (int i = 0; i < 5; i++) push(1'b0, 4'(2 + i), 8'(8'h40 + i), w);
        @(negedge clk);
        check("full_level", 32'(fifo_level), DEPTH);
        check("full_ready", 32'(cmd_ready), 0);
        push(1'b1, 4'd4, 8'h00, w);
        check("full_push_waited", 32'(w > 0), 1);
        @(negedge clk);
        check("full_level_after", 32'(fifo_level), DEPTH);
        wait_idle("full_idle");

        // Reset during the first cycle of a read.
        rdp0 = rd_pulses;
        push(1'b1, 4'd2, 8'h00, w);
        push(1'b0, 4'd3, 8'h11, w);
        push(1'b1, 4'd3, 8'h00, w);
        n = 0;
        @(negedge clk);
        while (psg_cs_n && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("abort_in_read", 32'(psg_cs_n), 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_cs_n",  32'(psg_cs_n), 1);
        check("abort_wr_n",  32'(psg_wr_n), 1);
        check("abort_level", 32'(fifo_level), 0);
        check("abort_busy",  32'(busy), 0);
        exp_bus_q.delete();
        exp_rd_q.delete();
        for (int i = 0; i < 16; i++) shadow[i] = psg_regs[i];
        repeat (10) @(negedge clk);
        check("abort_no_rd_valid", 32'(rd_pulses - rdp0), 0);

        // Random mixed stream.
        for (int i = 0; i < 40; i++) begin
            rr   = 1'($urandom_range(0, 1));
            ra   = 4'($urandom_range(0, 15));
            rdat = 8'($urandom_range(0, 255));
            push(rr, ra, rdat, w);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle("rand_idle");
        check("rand_bus_q_empty", 32'(exp_bus_q.size()), 0);
        check("rand_rd_q_empty",  32'(exp_rd_q.size()), 0);
        check("protocol_errors",  32'(proto_errs), 0);
        check("rd_valid_double",  32'(rd_double), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
